// File: rtl/cdb_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : cdb_arbiter_if
// Description : Bundle of functional-unit result inputs, the mispredict squash
//               and the Common Data Bus broadcast / stall outputs shared by
//               the CDB arbiter and the execute stage.
//               The PRF tag width defaults to the PRF_width macro.
// Revision    : 1.0  initial release
//==============================================================================
`ifndef PRF_width
`define PRF_width 6
`endif

interface cdb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int PRF_W  = `PRF_width
);
    logic                      ROB_branch_mispredict_in;
    logic [NUM_FU-1:0]         fu_valid_in;
    logic [NUM_FU*PRF_W-1:0]   fu_tag_in;
    logic [NUM_FU*64-1:0]      fu_value_in;
    logic                      CDB_valid_out;
    logic [PRF_W-1:0]          CDB_tag_out;
    logic [63:0]               CDB_value_out;
    logic [NUM_FU-1:0]         CDB_grant_out;
    logic [NUM_FU-1:0]         fu_stall_out;
    logic                      CDB_arb_stall_out;

    // Execute stage side: presents results, observes the broadcast.
    modport master (
        output ROB_branch_mispredict_in, fu_valid_in, fu_tag_in, fu_value_in,
        input  CDB_valid_out, CDB_tag_out, CDB_value_out, CDB_grant_out,
        input  fu_stall_out, CDB_arb_stall_out
    );

    // Arbiter side.
    modport slave (
        input  ROB_branch_mispredict_in, fu_valid_in, fu_tag_in, fu_value_in,
        output CDB_valid_out, CDB_tag_out, CDB_value_out, CDB_grant_out,
        output fu_stall_out, CDB_arb_stall_out
    );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : cdb_arbiter
// Description : Grants the single Common Data Bus to one completing functional
//               unit per cycle; losing results are parked in per-unit holding
//               slots and the owning unit (and the RS) are stalled until the
//               slot drains. Round-robin arbitration by default; defining
//               CDB_FIXED_PRIORITY_EN selects fixed lowest-index priority.
//               The PRF tag width defaults to the PRF_width macro.
// Revision    : 1.0  initial release
//==============================================================================
`ifndef PRF_width
`define PRF_width 6
`endif

module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int PRF_W  = `PRF_width
) (
    input  logic         clock,
    input  logic         reset,
    cdb_arbiter_if.slave cdb
);
    localparam int c_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Holding slots, one per unit
    logic [NUM_FU-1:0]   r_slot_v;
    logic [PRF_W-1:0]    r_slot_tag [NUM_FU];
    logic [63:0]         r_slot_val [NUM_FU];

    // Registered broadcast
    logic                r_cdb_valid;
    logic [PRF_W-1:0]    r_cdb_tag;
    logic [63:0]         r_cdb_value;
    logic [NUM_FU-1:0]   r_cdb_grant;

`ifndef CDB_FIXED_PRIORITY_EN
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_IDX_W-1:0]  w_next_ptr;
`endif

    logic [NUM_FU-1:0]   w_cand;
    logic [PRF_W-1:0]    w_cand_tag [NUM_FU];
    logic [63:0]         w_cand_val [NUM_FU];
    logic [NUM_FU-1:0]   w_eligible;
    logic                w_any;
    logic [c_IDX_W-1:0]  w_win_idx;
    logic [NUM_FU-1:0]   w_grant;
    logic [PRF_W-1:0]    w_win_tag;
    logic [63:0]         w_win_val;
    logic                w_flush;

    assign w_flush = reset | cdb.ROB_branch_mispredict_in;

    // A parked result takes precedence; the unit's live inputs are ignored
    // while its slot is occupied.
    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_cand
            assign w_cand[gi]     = r_slot_v[gi] | cdb.fu_valid_in[gi];
            assign w_cand_tag[gi] = r_slot_v[gi] ? r_slot_tag[gi]
                                                 : cdb.fu_tag_in[gi*PRF_W +: PRF_W];
            assign w_cand_val[gi] = r_slot_v[gi] ? r_slot_val[gi]
                                                 : cdb.fu_value_in[gi*64 +: 64];
        end
    endgenerate

    // Pick the winner: lowest eligible index, where eligibility is restricted
    // to indices at or after the pointer unless none qualify (the wrap case).
    always_comb begin
        w_any      = 1'b0;
        w_win_idx  = '0;
        w_eligible = w_cand;
`ifndef CDB_FIXED_PRIORITY_EN
        for (int i = 0; i < NUM_FU; i++) begin
            w_eligible[i] = w_cand[i] && (c_IDX_W'(i) >= r_rr_ptr);
        end
        if (w_eligible == '0) begin
            w_eligible = w_cand;
        end
`endif
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_any     = 1'b1;
                w_win_idx = c_IDX_W'(i);
            end
        end
    end

    // Decode the one-hot grant and select the winning tag/value (zero if idle).
    always_comb begin
        w_grant   = '0;
        w_win_tag = '0;
        w_win_val = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_any && (w_win_idx == c_IDX_W'(i))) begin
                w_grant[i] = 1'b1;
                w_win_tag  = w_cand_tag[i];
                w_win_val  = w_cand_val[i];
            end
        end
    end

`ifndef CDB_FIXED_PRIORITY_EN
    assign w_next_ptr = (w_win_idx == c_IDX_W'(NUM_FU - 1)) ? '0 : w_win_idx + 1'b1;

    // Round-robin pointer moves past the winner; holds when the bus is idle.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= w_next_ptr;
        end
    end
`endif

    // Broadcast register: winner of this edge is on the bus for one cycle.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_value <= '0;
            r_cdb_grant <= '0;
        end else begin
            r_cdb_valid <= w_any;
            r_cdb_tag   <= w_win_tag;
            r_cdb_value <= w_win_val;
            r_cdb_grant <= w_grant;
        end
    end

    // Slot update: a winning slot drains, a losing live result is parked.
    always_ff @(posedge clock) begin
        if (w_flush) begin
            r_slot_v <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_slot_tag[i] <= '0;
                r_slot_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_grant[i]) begin
                    r_slot_v[i] <= 1'b0;
                end else if (!r_slot_v[i] && cdb.fu_valid_in[i]) begin
                    r_slot_v[i]   <= 1'b1;
                    r_slot_tag[i] <= cdb.fu_tag_in[i*PRF_W +: PRF_W];
                    r_slot_val[i] <= cdb.fu_value_in[i*64 +: 64];
                end
            end
        end
    end

    // Stalls come straight from slot state, never from the inputs.
    assign cdb.CDB_valid_out     = r_cdb_valid;
    assign cdb.CDB_tag_out       = r_cdb_tag;
    assign cdb.CDB_value_out     = r_cdb_value;
    assign cdb.CDB_grant_out     = r_cdb_grant;
    assign cdb.fu_stall_out      = r_slot_v;
    assign cdb.CDB_arb_stall_out = |r_slot_v;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed scoreboard bench for cdb_arbiter. Expected broadcasts
//               are queued as stimulus is issued; a monitor pops and compares
//               on every cycle the bus is valid.
// Revision    : 1.0  initial release
//==============================================================================
module tb_cdb_arbiter;
    localparam int NUM_FU = 4;
    localparam int PRF_W  = 6;

    typedef struct packed {
        logic [PRF_W-1:0] tag;
        logic [63:0]      val;
        logic [3:0]       grant;
    } exp_t;

    logic clk;
    logic rst;
    logic mon_en;
    int   n_vec;
    int   n_fail;
    exp_t q[$];

    logic [PRF_W-1:0] d_t0 [7];
    logic [PRF_W-1:0] d_t2 [7];
    logic             d_v2 [7];
    logic [3:0]       d_st [7];

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .PRF_W(PRF_W)) bus ();

    cdb_arbiter #(.NUM_FU(NUM_FU), .PRF_W(PRF_W)) dut (
        .clock (clk),
        .reset (rst),
        .cdb   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [63:0] vf(input logic [PRF_W-1:0] t);
        return 64'hC0DE_0000_0000_0000 | 64'(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fu(input int i, input logic v, input logic [PRF_W-1:0] t,
                          input logic [63:0] val);
        bus.fu_valid_in[i]               = v;
        bus.fu_tag_in[i*PRF_W +: PRF_W] = t;
        bus.fu_value_in[i*64 +: 64]      = val;
    endtask

    task automatic clr_all();
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b0, '0, '0);
    endtask

    task automatic expect_b(input logic [PRF_W-1:0] t, input logic [63:0] v, input logic [3:0] g);
        exp_t e;
        e.tag = t; e.val = v; e.grant = g;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid broadcast must match the head of the scoreboard;
    // idle cycles must show an all-zero bus.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.CDB_valid_out === 1'b1) begin
                exp_t e;
                n_vec++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bcast_unexpected: got tag=%0d grant=%b expected no broadcast",
                             bus.CDB_tag_out, bus.CDB_grant_out);
                end else begin
                    e = q.pop_front();
                    if (bus.CDB_tag_out !== e.tag || bus.CDB_value_out !== e.val ||
                        bus.CDB_grant_out !== e.grant) begin
                        n_fail++;
                        $display("FAIL bcast: got tag=%0d val=%0h grant=%b expected tag=%0d val=%0h grant=%b",
                                 bus.CDB_tag_out, bus.CDB_value_out, bus.CDB_grant_out,
                                 e.tag, e.val, e.grant);
                    end
                end
            end else begin
                n_vec++;
                if (bus.CDB_valid_out !== 1'b0 || bus.CDB_tag_out !== '0 ||
                    bus.CDB_value_out !== '0 || bus.CDB_grant_out !== '0) begin
                    n_fail++;
                    $display("FAIL idle_bus: got valid=%b tag=%0d val=%0h grant=%b expected all zero",
                             bus.CDB_valid_out, bus.CDB_tag_out, bus.CDB_value_out, bus.CDB_grant_out);
                end
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        bus.ROB_branch_mispredict_in = 1'b0;
        bus.fu_valid_in = '0;
        bus.fu_tag_in   = '0;
        bus.fu_value_in = '0;

        // Reset while every unit requests: outputs stay zero.
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, PRF_W'(11 + i), vf(PRF_W'(11 + i)));
        tick(); tick();
        mon_en = 1'b1;
        chk("rst_valid", 64'(bus.CDB_valid_out), 0);
        chk("rst_tag", 64'(bus.CDB_tag_out), 0);
        chk("rst_value", bus.CDB_value_out, 0);
        chk("rst_grant", 64'(bus.CDB_grant_out), 0);
        chk("rst_fu_stall", 64'(bus.fu_stall_out), 0);
        chk("rst_arb_stall", 64'(bus.CDB_arb_stall_out), 0);

        // First edge out of reset: unit 0 wins, others parked; then reset discards them.
        expect_b(11, vf(11), 4'b0001);
        rst = 1'b0;
        tick();
        chk("a_fu_stall", 64'(bus.fu_stall_out), 64'b1110);
        chk("a_arb_stall", 64'(bus.CDB_arb_stall_out), 1);
        clr_all();
        rst = 1'b1;
        tick();
        chk("a_rst_valid", 64'(bus.CDB_valid_out), 0);
        chk("a_rst_fu_stall", 64'(bus.fu_stall_out), 0);
        chk("a_rst_arb_stall", 64'(bus.CDB_arb_stall_out), 0);
        rst = 1'b0;

        // Single requester on unit 1.
        set_fu(1, 1'b1, 5, 64'h55);
        expect_b(5, 64'h55, 4'b0010);
        tick();
        clr_all();
        chk("b_fu_stall", 64'(bus.fu_stall_out), 0);
        chk("b_arb_stall", 64'(bus.CDB_arb_stall_out), 0);
        tick();
        chk("b_idle_valid", 64'(bus.CDB_valid_out), 0);

        // All four at once; parked results drain one per cycle.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, PRF_W'(1 + i), vf(PRF_W'(1 + i)));
        expect_b(1, vf(1), 4'b0001);
        tick();
        chk("c1_fu_stall", 64'(bus.fu_stall_out), 64'b1110);
        chk("c1_arb_stall", 64'(bus.CDB_arb_stall_out), 1);
        set_fu(0, 1'b0, '0, '0);
        expect_b(2, vf(2), 4'b0010);
        tick();
        chk("c2_fu_stall", 64'(bus.fu_stall_out), 64'b1100);
        set_fu(1, 1'b0, '0, '0);
        expect_b(3, vf(3), 4'b0100);
        tick();
        chk("c3_fu_stall", 64'(bus.fu_stall_out), 64'b1000);
        chk("c3_arb_stall", 64'(bus.CDB_arb_stall_out), 1);
        set_fu(2, 1'b0, '0, '0);
        expect_b(4, vf(4), 4'b1000);
        tick();
        chk("c4_fu_stall", 64'(bus.fu_stall_out), 0);
        chk("c4_arb_stall", 64'(bus.CDB_arb_stall_out), 0);
        set_fu(3, 1'b0, '0, '0);
        tick();

`ifndef CDB_FIXED_PRIORITY_EN
        // Units 0 and 2 continuously busy: grants alternate.
        d_t0 = '{30, 31, 31, 32, 32, 33, 33};
        d_t2 = '{40, 40, 41, 41, 42, 42, 0};
        d_v2 = '{1, 1, 1, 1, 1, 1, 0};
        d_st = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0000};
        expect_b(30, vf(30), 4'b0001);
        expect_b(40, vf(40), 4'b0100);
        expect_b(31, vf(31), 4'b0001);
        expect_b(41, vf(41), 4'b0100);
        expect_b(32, vf(32), 4'b0001);
        expect_b(42, vf(42), 4'b0100);
        expect_b(33, vf(33), 4'b0001);
        for (int k = 0; k < 7; k++) begin
            set_fu(0, 1'b1, d_t0[k], vf(d_t0[k]));
            set_fu(2, d_v2[k], d_t2[k], vf(d_t2[k]));
            tick();
            chk($sformatf("d%0d_fu_stall", k), 64'(bus.fu_stall_out), 64'(d_st[k]));
        end
        clr_all();
        tick();
`else
        // Fixed priority: unit 0 always fresh, unit 2 starves until unit 0 stops.
        for (int k = 0; k < 6; k++) begin
            set_fu(0, 1'b1, PRF_W'(30 + k), vf(PRF_W'(30 + k)));
            set_fu(2, 1'b1, 40, vf(40));
            expect_b(PRF_W'(30 + k), vf(PRF_W'(30 + k)), 4'b0001);
            tick();
            chk($sformatf("dfx%0d_fu_stall", k), 64'(bus.fu_stall_out), 64'b0100);
        end
        expect_b(40, vf(40), 4'b0100);
        clr_all();
        tick();
        chk("dfx_drain_stall", 64'(bus.fu_stall_out), 0);
        tick();
`endif

        // Mispredict squashes parked results; a fresh unit-2 request wins at once.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, PRF_W'(50 + i), vf(PRF_W'(50 + i)));
        expect_b(50, vf(50), 4'b0001);
        tick();
        chk("e_fu_stall", 64'(bus.fu_stall_out), 64'b1110);
        bus.ROB_branch_mispredict_in = 1'b1;
        set_fu(0, 1'b1, 54, vf(54));
        tick();
        bus.ROB_branch_mispredict_in = 1'b0;
        chk("e_mp_valid", 64'(bus.CDB_valid_out), 0);
        chk("e_mp_fu_stall", 64'(bus.fu_stall_out), 0);
        chk("e_mp_arb_stall", 64'(bus.CDB_arb_stall_out), 0);
        clr_all();
        set_fu(2, 1'b1, 60, vf(60));
        expect_b(60, vf(60), 4'b0100);
        tick();
        set_fu(2, 1'b0, '0, '0);
        chk("e_new_grant", 64'(bus.CDB_grant_out), 64'b0100);
        chk("e_new_fu_stall", 64'(bus.fu_stall_out), 0);
        tick();

        // Stalled unit 1 changes its live tag; the parked tag 7 is what goes out.
        rst = 1'b1; tick(); rst = 1'b0;
        set_fu(0, 1'b1, 20, vf(20));
        set_fu(1, 1'b1, 7, vf(7));
        expect_b(20, vf(20), 4'b0001);
        expect_b(7, vf(7), 4'b0010);
        tick();
        chk("f1_fu_stall", 64'(bus.fu_stall_out), 64'b0010);
        set_fu(0, 1'b0, '0, '0);
        set_fu(1, 1'b1, 9, vf(9));
        tick();
        set_fu(1, 1'b0, '0, '0);
        chk("f2_fu_stall", 64'(bus.fu_stall_out), 0);
        tick(); tick(); tick();

        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single Common Data Bus among the execute-stage functional units (ALU, MULT, branch, LSQ). Each cycle it grants the bus to one completing unit and parks each losing result in a per-unit holding slot. It also back-pressures the units and the RS: its stall output drives the RS `ex_CDB_arb_stall_in`, and its broadcast tag drives `ex_CDB_tag_in`.

## Interface
Parameters:
- `NUM_FU`, default 4: number of requesting functional units. Index 0 = ALU, 1 = MULT, 2 = branch, 3 = LSQ.
- `PRF_W`, default `` `PRF_width ``: physical register tag width.

Ports:
- `clock`  in  1  sole clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ROB_branch_mispredict_in`  in  1  squashes all buffered and in-flight CDB state.
- `fu_valid_in`  in  NUM_FU  per-unit result-ready strobe.
- `fu_tag_in`  in  NUM_FU*PRF_W  per-unit destination PRF tag. Unit i occupies bits [i*PRF_W +: PRF_W].
- `fu_value_in`  in  NUM_FU*64  per-unit result. Unit i occupies bits [i*64 +: 64].
- `CDB_valid_out`  out  1  broadcast valid.
- `CDB_tag_out`  out  PRF_W  broadcast tag.
- `CDB_value_out`  out  64  broadcast value.
- `CDB_grant_out`  out  NUM_FU  one-hot source of the current broadcast.
- `fu_stall_out`  out  NUM_FU  unit i must hold its output and must not complete new work.
- `CDB_arb_stall_out`  out  1  to the RS: do not issue this cycle.

## Operation
- State:
  - per-unit holding slot (`slot_v`, tag, value);
  - round-robin pointer `rr_ptr` of width log2(NUM_FU), reset value 0;
  - registered CDB output.
- Candidate for unit i:
  - the slot contents if `slot_v[i]` is set;
  - otherwise the incoming result if `fu_valid_in[i]` is set.
- Incoming `fu_valid_in[i]` is ignored while `slot_v[i]` is set. The unit is stalled and keeps presenting the same result.
- Arbitration: the first candidate at or after `rr_ptr`, in increasing index order with wrap from NUM_FU-1 to 0.
  - The winner is registered to `CDB_*_out`.
  - `rr_ptr` becomes (winner+1) mod NUM_FU.
  - With no candidate, `rr_ptr` is unchanged.
- Winner coming from a slot: that slot is cleared.
- Losing incoming results are captured into their slots.
- Losing slot contents remain in their slots.
- No candidate: `CDB_valid_out`=0. Tag, value and grant are driven to 0 whenever valid is 0.
- `fu_stall_out[i]` = `slot_v[i]`.
- `CDB_arb_stall_out` = OR of all `slot_v`. Both stall outputs are decoded only from registers; there is no combinational path from the inputs.
- Mispredict, evaluated at the edge:
  - all `slot_v` cleared;
  - `CDB_valid_out` cleared;
  - `rr_ptr` set to 0;
  - incoming results that cycle are dropped.
- `reset` has the same effect as mispredict and takes priority over it. Reset mid-arbitration discards all pending results.
- Every output resets to 0.

## Timing
- Latency: a result winning at edge t appears on `CDB_*_out` from t until t+1.
- At most one broadcast per cycle. Tags on the bus are unique per cycle.
- Starvation bound (round-robin): a pending candidate is granted within NUM_FU cycles of first presentation.
- Stall timing:
  - `fu_stall_out[i]` rises in the cycle after unit i loses arbitration.
  - It falls in the cycle after its slot wins.
- The RS sees `CDB_arb_stall_out` one cycle after contention arises. The RS holds its issued instruction in its own latch, so this bound is sufficient.
- Boundary cases:
  - All slots full: the arbiter still grants one per cycle. `CDB_arb_stall_out` clears one cycle after the last slot drains.
  - Only the pointed-to unit requesting: granted immediately, pointer advances.
  - Single requester every cycle (slot stays empty): back-to-back grants, no stall.

## Configuration
- `CDB_FIXED_PRIORITY_EN`
  - Defined: fixed priority, lowest index wins. `rr_ptr` is removed and there is no starvation bound.
  - Undefined (default): round-robin as above.
  - All other behaviour is identical in both builds.

## Test plan
- Reset with `fu_valid_in`=1111 → after reset all outputs 0, `rr_ptr`=0. First non-reset edge broadcasts tag of unit 0.
- Unit 1 alone, tag 5, value 0x55 → next cycle `CDB_valid_out`=1, tag 5, value 0x55, grant 0010, both stalls 0.
- Units 0–3 valid together with tags 1–4, then unit 0's `fu_valid_in` dropped:
  - cycle 1: tag 1 broadcast, `fu_stall_out`=1110, `CDB_arb_stall_out`=1;
  - cycles 2–4: tags 2, 3, 4 broadcast;
  - after cycle 4: `CDB_arb_stall_out`=0.
- Units 0 and 2 requesting every cycle → grants alternate 0001, 0100, 0001, …. With `CDB_FIXED_PRIORITY_EN`, unit 0 supplying a fresh tag each cycle → unit 2 is never granted and `fu_stall_out[2]` stays 1.
- Slots 1–3 occupied, `ROB_branch_mispredict_in`=1 for one cycle → next cycle `CDB_valid_out`=0, `fu_stall_out`=0000, `CDB_arb_stall_out`=0. A new unit-2 request then wins immediately (`rr_ptr`=0, only candidate).
- Unit 1 stalled holding tag 7 while `fu_tag_in` for unit 1 changes to 9 → tag 7 is broadcast and tag 9 is never broadcast.
